// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port memory, one outstanding transaction.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is data-first.
module mem_arbiter #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    output logic            d_gnt_o,
    output logic            d_valid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ready_i,
    output logic            err_o,
    output logic            busy_o
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic       OwnFetch   = 1'b0;
    localparam logic       OwnData    = 1'b1;
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            if_gnt_q, if_gnt_d;
    logic            d_gnt_q, d_gnt_d;
    logic            if_valid_q, if_valid_d;
    logic            d_valid_q, d_valid_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            sel_data;
`ifdef ARB_ROUND_ROBIN_EN
    logic            last_owner_q, last_owner_d;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_gnt_d   = 1'b0;
        d_gnt_d    = 1'b0;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
        sel_data     = (if_req_i && d_req_i) ? (last_owner_q == OwnFetch) : d_req_i;
`else
        sel_data     = d_req_i;
`endif

        case (state_q)
            StIdle: begin
                if (if_req_i || d_req_i) begin
                    state_d = StBusy;
                    owner_d = sel_data ? OwnData : OwnFetch;
                    cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = sel_data ? OwnData : OwnFetch;
`endif
                    if (sel_data) begin
                        addr_d  = d_addr_i;
                        we_d    = d_we_i;
                        wdata_d = d_wdata_i;
                        d_gnt_d = 1'b1;
                    end else begin
                        addr_d   = if_addr_i;
                        we_d     = 1'b0;
                        if_gnt_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                // A ready arriving in the same cycle the count hits the limit still completes.
                if (mem_ready_i) begin
                    state_d = StIdle;
                    if (owner_q == OwnData) begin
                        d_valid_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = mem_rdata_i;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end
                end else if (cnt_q == TimeoutCnt) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    if (owner_q == OwnData) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            owner_q    <= OwnFetch;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_gnt_q   <= if_gnt_d;
            d_gnt_q    <= d_gnt_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_owner_q <= OwnFetch;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    // mem_req follows state directly so an asynchronous reset drops it at once.
    assign mem_req_o   = (state_q == StBusy);
    assign busy_o      = (state_q == StBusy);
    assign mem_we_o    = (state_q == StBusy) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_gnt_o    = if_gnt_q;
    assign d_gnt_o     = d_gnt_q;
    assign if_valid_o  = if_valid_q;
    assign d_valid_o   = d_valid_q;
    assign err_o       = err_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;

endmodule
